// File: rtl/mem_ram_ctrl_if.sv
// Bus-side handshake bundle between the RAM controller (master) and the
// memory bus (slave): a level request held until a one-cycle ack.
interface mem_ram_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  bus_req_o;
    logic                  bus_we_o;
    logic [ADDR_WIDTH-1:0] bus_addr_o;
    logic [DATA_WIDTH-1:0] bus_wdata_o;
    logic                  bus_ack_i;
    logic [DATA_WIDTH-1:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
        input  bus_ack_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
        output bus_ack_i, bus_rdata_i
    );
endinterface

// File: rtl/mem_ram_ctrl.sv
// Mem-stage RAM controller: turns loads, full-word stores and partial stores
// (read-merge-write) into bus transactions, stalling the pipeline meanwhile.
module mem_ram_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ram_ce_i,
    input  logic                  mem_access_i,
    input  logic                  ram_we_i,
    input  logic                  ram_wfull_i,
    input  logic [ADDR_WIDTH-1:0] ram_addr_i,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic                  stall_o,
    output logic                  err_o,
    mem_ram_ctrl_if.master        bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD    = 3'd1;
    localparam logic [2:0] MERGE = 3'd2;
    localparam logic [2:0] WR    = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0] state;
    logic [7:0] wait_cnt;
    logic       wr_flag;
    logic       start;
    logic       start_full;
    logic       timeout;

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        start      = ram_ce_i & mem_access_i;
        start_full = start & ram_we_i & ram_wfull_i;
        // Ack in the same cycle as the last wait cycle wins over the timeout.
        timeout    = (wait_cnt == TIMEOUT_LAST) & ~bus.bus_ack_i;
        stall_o    = rst_i & (((state == IDLE) & start) |
                              (state == RD) | (state == MERGE) | (state == WR));
    end

    // NOTE: sequential state uses non-blocking assignments only, and the
    // synchronous reset is the first branch inside the clocked block.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            wr_flag         <= 1'b0;
            err_o           <= 1'b0;
            ram_data_o      <= '0;
            bus.bus_req_o   <= 1'b0;
            bus.bus_we_o    <= 1'b0;
            bus.bus_addr_o  <= '0;
            bus.bus_wdata_o <= '0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bus.bus_addr_o <= ram_addr_i;
                        bus.bus_req_o  <= 1'b1;
                        wr_flag        <= ram_we_i;
                        wait_cnt       <= '0;
                        if (start_full) begin
                            state           <= WR;
                            bus.bus_we_o    <= 1'b1;
                            bus.bus_wdata_o <= ram_data_i;
                        end else begin
                            state        <= RD;
                            bus.bus_we_o <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (bus.bus_ack_i) begin
                        bus.bus_req_o <= 1'b0;
                        ram_data_o    <= bus.bus_rdata_i;
                        state         <= wr_flag ? MERGE : DONE;
                    end else if (timeout) begin
                        bus.bus_req_o <= 1'b0;
                        ram_data_o    <= '0;
                        err_o         <= 1'b1;
                        state         <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                MERGE: begin
                    // The mem stage has merged its bytes into the old word by now.
                    bus.bus_wdata_o <= ram_data_i;
                    bus.bus_we_o    <= 1'b1;
                    bus.bus_req_o   <= 1'b1;
                    wait_cnt        <= '0;
                    state           <= WR;
                end
                WR: begin
                    if (bus.bus_ack_i) begin
                        bus.bus_req_o <= 1'b0;
                        bus.bus_we_o  <= 1'b0;
                        state         <= DONE;
                    end else if (timeout) begin
                        bus.bus_req_o <= 1'b0;
                        bus.bus_we_o  <= 1'b0;
                        err_o         <= 1'b1;
                        state         <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ram_ctrl.sv
// Directed bench for mem_ram_ctrl: load, partial store, full store with wait
// states, read timeout, reset mid-write and idle chip-enable traffic.
module tb_mem_ram_ctrl;

    logic        clk;
    logic        rst_i;
    logic        ram_ce_i;
    logic        mem_access_i;
    logic        ram_we_i;
    logic        ram_wfull_i;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_data_i;
    logic [31:0] ram_data_o;
    logic        stall_o;
    logic        err_o;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Bus observation, written only by the monitor below.
    int          stall_cnt = 0;
    int          rd_cnt    = 0;
    int          wr_cnt    = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;

    mem_ram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_ram_ctrl #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .ram_ce_i    (ram_ce_i),
        .mem_access_i(mem_access_i),
        .ram_we_i    (ram_we_i),
        .ram_wfull_i (ram_wfull_i),
        .ram_addr_i  (ram_addr_i),
        .ram_data_i  (ram_data_i),
        .ram_data_o  (ram_data_o),
        .stall_o     (stall_o),
        .err_o       (err_o),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (stall_o) stall_cnt <= stall_cnt + 1;
        if (bus.bus_req_o && bus.bus_ack_i) begin
            if (bus.bus_we_o) begin
                wr_cnt     <= wr_cnt + 1;
                last_waddr <= bus.bus_addr_o;
                last_wdata <= bus.bus_wdata_o;
            end else begin
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Registered outputs are stable 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic we, input logic full, input logic [31:0] addr,
                          input logic [31:0] data);
        ram_ce_i     = 1'b1;
        mem_access_i = 1'b1;
        ram_we_i     = we;
        ram_wfull_i  = full;
        ram_addr_i   = addr;
        ram_data_i   = data;
    endtask

    task automatic clear_op();
        ram_ce_i     = 1'b0;
        mem_access_i = 1'b0;
        ram_we_i     = 1'b0;
        ram_wfull_i  = 1'b0;
        ram_addr_i   = '0;
        ram_data_i   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          stall_base;
        int          rd_base;
        int          wr_base;
        logic [31:0] old_word;
        logic [31:0] merged;

        rst_i           = 1'b0;
        bus.bus_ack_i   = 1'b0;
        bus.bus_rdata_i = '0;
        clear_op();

        // Reset state, with a pending access that must not raise stall.
        cyc();
        cyc();
        set_op(1'b0, 1'b0, 32'h0000_0100, '0);
        #1;
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_req", 32'(bus.bus_req_o), 32'h0);
        check("rst_we", 32'(bus.bus_we_o), 32'h0);
        check("rst_addr", bus.bus_addr_o, 32'h0);
        check("rst_wdata", bus.bus_wdata_o, 32'h0);
        check("rst_rdata", ram_data_o, 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        clear_op();
        rst_i = 1'b1;
        cyc();

        // LW 0x100, ack in first RD cycle.
        stall_base = stall_cnt;
        rd_base    = rd_cnt;
        set_op(1'b0, 1'b0, 32'h0000_0100, '0);
        #1;
        check("lw_idle_stall", 32'(stall_o), 32'h1);
        cyc();
        check("lw_rd_req", 32'(bus.bus_req_o), 32'h1);
        check("lw_rd_we", 32'(bus.bus_we_o), 32'h0);
        check("lw_rd_addr", bus.bus_addr_o, 32'h0000_0100);
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = 32'hDEAD_BEEF;
        cyc();
        bus.bus_ack_i = 1'b0;
        check("lw_done_req", 32'(bus.bus_req_o), 32'h0);
        check("lw_done_stall", 32'(stall_o), 32'h0);
        check("lw_done_data", ram_data_o, 32'hDEAD_BEEF);
        check("lw_done_err", 32'(err_o), 32'h0);
        check("lw_stall_cycles", 32'(stall_cnt - stall_base), 32'd2);
        check("lw_read_count", 32'(rd_cnt - rd_base), 32'd1);
        clear_op();
        cyc();

        // SB of 0xAA into byte 0x101; the mem stage presents the word address.
        stall_base = stall_cnt;
        old_word   = 32'h1122_3344;
        set_op(1'b1, 1'b0, 32'h0000_0100, '0);
        cyc();
        check("sb_rd_we", 32'(bus.bus_we_o), 32'h0);
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = old_word;
        cyc();
        bus.bus_ack_i = 1'b0;
        check("sb_merge_req", 32'(bus.bus_req_o), 32'h0);
        check("sb_merge_old", ram_data_o, 32'h1122_3344);
        check("sb_merge_stall", 32'(stall_o), 32'h1);
        merged     = (old_word & 32'hFFFF_00FF) | 32'h0000_AA00;
        ram_data_i = merged;
        cyc();
        check("sb_wr_req", 32'(bus.bus_req_o), 32'h1);
        check("sb_wr_we", 32'(bus.bus_we_o), 32'h1);
        check("sb_wr_data", bus.bus_wdata_o, 32'h1122_AA44);
        bus.bus_ack_i = 1'b1;
        cyc();
        bus.bus_ack_i = 1'b0;
        check("sb_done_stall", 32'(stall_o), 32'h0);
        check("sb_stall_cycles", 32'(stall_cnt - stall_base), 32'd4);
        check("sb_waddr", last_waddr, 32'h0000_0100);
        check("sb_wdata", last_wdata, 32'h1122_AA44);
        check("sb_rdata_kept", ram_data_o, 32'h1122_3344);
        clear_op();
        cyc();

        // SW 0x200 with ack in the 4th WR cycle: also the last wait cycle.
        stall_base = stall_cnt;
        rd_base    = rd_cnt;
        wr_base    = wr_cnt;
        set_op(1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("sw_req_stable", 32'(bus.bus_req_o), 32'h1);
            check("sw_we_stable", 32'(bus.bus_we_o), 32'h1);
            check("sw_addr_stable", bus.bus_addr_o, 32'h0000_0200);
            check("sw_wdata_stable", bus.bus_wdata_o, 32'hCAFE_F00D);
            if (k == 3) bus.bus_ack_i = 1'b1;
        end
        cyc();
        bus.bus_ack_i = 1'b0;
        check("sw_done_err", 32'(err_o), 32'h0);
        check("sw_done_req", 32'(bus.bus_req_o), 32'h0);
        check("sw_stall_cycles", 32'(stall_cnt - stall_base), 32'd5);
        check("sw_no_read", 32'(rd_cnt - rd_base), 32'd0);
        check("sw_write_count", 32'(wr_cnt - wr_base), 32'd1);
        check("sw_wdata", last_wdata, 32'hCAFE_F00D);
        clear_op();
        cyc();

        // Read with no ack times out after 4 RD cycles.
        set_op(1'b0, 1'b0, 32'h0000_0300, '0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("to_rd_req", 32'(bus.bus_req_o), 32'h1);
            check("to_rd_err", 32'(err_o), 32'h0);
        end
        cyc();
        check("to_done_req", 32'(bus.bus_req_o), 32'h0);
        check("to_done_err", 32'(err_o), 32'h1);
        check("to_done_data", ram_data_o, 32'h0);
        clear_op();
        bus.bus_ack_i = 1'b1;
        cyc();
        check("to_err_pulse", 32'(err_o), 32'h0);
        cyc();
        bus.bus_ack_i = 1'b0;
        check("stray_ack_req", 32'(bus.bus_req_o), 32'h0);
        check("stray_ack_stall", 32'(stall_o), 32'h0);

        // Reset in the middle of a write aborts it; a late ack is ignored.
        wr_base = wr_cnt;
        set_op(1'b1, 1'b1, 32'h0000_0400, 32'h1234_5678);
        cyc();
        check("rw_wr_req", 32'(bus.bus_req_o), 32'h1);
        rst_i = 1'b0;
        clear_op();
        cyc();
        check("rw_rst_req", 32'(bus.bus_req_o), 32'h0);
        check("rw_rst_addr", bus.bus_addr_o, 32'h0);
        rst_i         = 1'b1;
        bus.bus_ack_i = 1'b1;
        cyc();
        bus.bus_ack_i = 1'b0;
        check("rw_late_ack_req", 32'(bus.bus_req_o), 32'h0);
        check("rw_late_ack_err", 32'(err_o), 32'h0);
        check("rw_no_write", 32'(wr_cnt - wr_base), 32'd0);

        // Next LW proceeds normally.
        stall_base = stall_cnt;
        set_op(1'b0, 1'b0, 32'h0000_0500, '0);
        cyc();
        check("rw_lw_addr", bus.bus_addr_o, 32'h0000_0500);
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = 32'h0BAD_F00D;
        cyc();
        bus.bus_ack_i = 1'b0;
        check("rw_lw_data", ram_data_o, 32'h0BAD_F00D);
        check("rw_lw_stall_cycles", 32'(stall_cnt - stall_base), 32'd2);
        clear_op();
        cyc();

        // Chip enable without a memory access never starts a transaction.
        ram_ce_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("ce_only_stall", 32'(stall_o), 32'h0);
            cyc();
            check("ce_only_req", 32'(bus.bus_req_o), 32'h0);
        end
        clear_op();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_ram_ctrl.md
MEM_RAM_CTRL -- requirements
Module: mem_ram_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 32, bus address width; DATA_WIDTH, 32, data width; TIMEOUT_CYCLES, 255, maximum cycles to wait for bus_ack_i (1..255).
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 SHALL have port clk_i, in, 1, rising-edge clock.
REQ-004 SHALL have port rst_i, in, 1, synchronous active-low reset.
REQ-005 SHALL have port ram_ce_i, in, 1, chip enable from mem stage.
REQ-006 SHALL have port mem_access_i, in, 1, current mem op is a load or store.
REQ-007 SHALL have port ram_we_i, in, 1, write request from mem stage.
REQ-008 SHALL have port ram_wfull_i, in, 1, write covers a full word (SW), so no read is needed.
REQ-009 SHALL have port ram_addr_i, in, ADDR_WIDTH, access address.
REQ-010 SHALL have port ram_data_i, in, DATA_WIDTH, merged write data from mem stage.
REQ-011 SHALL have port ram_data_o, out, DATA_WIDTH, registered read word returned to mem stage.
REQ-012 SHALL have port stall_o, out, 1, pipeline hold request.
REQ-013 SHALL have port err_o, out, 1, one-cycle bus timeout pulse.
REQ-014 SHALL have bus ports: bus_req_o, out, 1; bus_we_o, out, 1; bus_addr_o, out, ADDR_WIDTH; bus_wdata_o, out, DATA_WIDTH; bus_ack_i, in, 1; bus_rdata_i, in, DATA_WIDTH.

Function
REQ-015 SHALL implement FSM states IDLE, RD, MERGE, WR, DONE; all outputs except stall_o are registered.
REQ-016 IDLE: ram_ce_i & mem_access_i & (!ram_we_i | !ram_wfull_i) -> RD; ram_ce_i & mem_access_i & ram_we_i & ram_wfull_i -> WR, with bus_wdata_o <= ram_data_i; otherwise stay in IDLE.
REQ-017 On leaving IDLE, SHALL latch ram_addr_i into bus_addr_o and ram_we_i into an internal write flag; bus_addr_o SHALL be held until DONE.
REQ-018 RD: bus_req_o=1, bus_we_o=0; bus_ack_i high -> ram_data_o <= bus_rdata_i, then MERGE if the write flag is set, else DONE.
REQ-019 MERGE: lasts one cycle with ram_data_o holding the old word so the mem stage can merge it; bus_wdata_o <= ram_data_i; -> WR.
REQ-020 WR: bus_req_o=1, bus_we_o=1; bus_ack_i high -> DONE; ram_data_o unchanged.
REQ-021 Handshake: bus_req_o, bus_we_o, bus_addr_o and bus_wdata_o SHALL stay stable while bus_req_o=1 and bus_ack_i=0.
REQ-022 Handshake: bus_req_o SHALL drop in the cycle after ack is sampled.
REQ-023 Handshake: bus_ack_i SHALL be ignored while bus_req_o=0.
REQ-024 Timeout: an 8-bit wait counter SHALL clear on entry to RD or WR and increment each cycle without ack.
REQ-025 Timeout: when the counter reaches TIMEOUT_CYCLES-1 without ack, the FSM SHALL go to DONE with err_o=1 for the DONE cycle; a timed-out read sets ram_data_o=0; a timed-out RD of a write skips MERGE and WR.
REQ-026 DONE: bus_req_o=0, stall_o=0 for exactly one cycle; -> IDLE. The pipeline advances in this cycle, so the next op is seen in IDLE.
REQ-027 stall_o (combinational) = (IDLE & start condition of REQ-016) | state in {RD, MERGE, WR}.
REQ-028 Latency with zero-wait ack: read = 2 stall cycles, DONE on 3rd; partial write = 4 stall cycles; full-word write = 2 stall cycles.
REQ-029 Ack arriving in the same cycle the timeout fires SHALL take priority: the access completes normally and err_o=0.
REQ-030 ram_data_o SHALL hold its value from the last read ack until the next read ack, timeout or reset.

Reset
REQ-031 With rst_i=0 at a rising edge: state=IDLE, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0, ram_data_o=0, err_o=0, wait counter=0.
REQ-032 While rst_i=0, stall_o SHALL be 0.
REQ-033 Reset mid-access SHALL abort the access: bus_req_o=0 on the next cycle, and an ack arriving afterwards is ignored.

Verification
REQ-034 LW at 0x100, ack in the 1st RD cycle with rdata 0xDEADBEEF -> stall_o high 2 cycles; ram_data_o=0xDEADBEEF in DONE; one read request on the bus.
REQ-035 SB at 0x101 with mem stage merging byte 0xAA, old word 0x11223344 -> bus read then bus write of 0x1122AA44 to 0x100; stall_o high 4 cycles.
REQ-036 SW at 0x200, data 0xCAFEF00D, ack delayed 3 cycles -> no read issued; write request stable for 4 cycles; stall_o=1 for 5 cycles.
REQ-037 Read with no ack, TIMEOUT_CYCLES=4 -> bus_req_o drops after 4 RD cycles; err_o pulses once; ram_data_o=0.
REQ-038 rst_i=0 during WR -> bus_req_o=0 next cycle; a later ack causes no state change; next LW proceeds normally.
REQ-039 ram_ce_i=1 with mem_access_i=0 for 10 cycles -> bus_req_o stays 0 and stall_o stays 0.
